// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the test-RAM port arbiter: FSM states, grant
// encodings and the byte-lane merge / word-index helpers.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_I_ACC,
    ST_D_ACC,
    ST_D_RMW_WR
  } state_t;

  localparam logic       GRANT_I = 1'b0;
  localparam logic       GRANT_D = 1'b1;
  localparam logic [3:0] BE_FULL = 4'b1111;

  // Lane n takes the new byte when be[n] is set, otherwise keeps the RAM byte.
  function automatic logic [31:0] byte_merge(input logic [3:0]  be,
                                             input logic [31:0] wdata,
                                             input logic [31:0] old_data);
    logic [31:0] res;
    for (int n = 0; n < 4; n++) begin
      res[8*n +: 8] = be[n] ? wdata[8*n +: 8] : old_data[8*n +: 8];
    end
    return res;
  endfunction

  function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
    return {2'b00, byte_addr[31:2]};
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; on a tie the requester that did not win last
// time gets the grant. last_grant resets to D so instruction wins first.
module rr_arbiter2
  import mem_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       req_i,
  input  logic       req_d,
  output logic [1:0] grant,
  output logic       last_grant
);

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req_i && req_d) begin
        grant = (last_grant == GRANT_D) ? 2'b01 : 2'b10;
      end else if (req_i) begin
        grant = 2'b01;
      end else if (req_d) begin
        grant = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GRANT_D;
    end else if (|grant) begin
      last_grant <= grant[1] ? GRANT_D : GRANT_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port 32-bit test RAM between the instruction and data
// masters; partial data writes become a read-modify-write pair.
module mem_port_arbiter
  import mem_bus_pkg::*;
#(
  parameter int RAM_WORDS = 2048,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic [31:0]       i_readdata,
  output logic              i_waitrequest,
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [3:0]        d_byteenable,
  input  logic [31:0]       d_writedata,
  output logic [31:0]       d_readdata,
  output logic              d_waitrequest,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_read,
  output logic              ram_write,
  output logic [31:0]       ram_writedata,
  input  logic [31:0]       ram_readdata
);

  localparam logic [ADDR_W-1:0] RAM_LIMIT = ADDR_W'(RAM_WORDS);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merge_q;
  logic [3:0]        be_q;
  logic              wr_q;
  logic [1:0]        grant;
  logic              last_grant;
  logic              d_req;
  logic [ADDR_W-1:0] widx;
  logic              in_range;
  logic              partial;

  assign d_req    = d_read | d_write;
  assign widx     = word_index(addr_q);
  assign in_range = (widx < RAM_LIMIT);
  assign partial  = wr_q && (be_q != BE_FULL) && (be_q != 4'b0000);

  rr_arbiter2 u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (state_q == ST_IDLE),
    .req_i      (i_read),
    .req_d      (d_req),
    .grant      (grant),
    .last_grant (last_grant)
  );

  // Request latch and merge register; write wins when read and write are both set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant[0]) begin
        addr_q <= i_address;
        wr_q   <= 1'b0;
      end else if (grant[1]) begin
        addr_q  <= d_address;
        wdata_q <= d_writedata;
        be_q    <= d_byteenable;
        wr_q    <= d_write;
      end
      if (state_q == ST_D_ACC && partial) begin
        merge_q <= byte_merge(be_q, wdata_q, ram_readdata);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ram_address   = '0;
    ram_read      = 1'b0;
    ram_write     = 1'b0;
    ram_writedata = '0;
    i_readdata    = '0;
    d_readdata    = '0;
    i_waitrequest = i_read;
    d_waitrequest = d_req;
    case (state_q)
      ST_IDLE: begin
        if (grant[0]) begin
          state_d = ST_I_ACC;
        end else if (grant[1]) begin
          state_d = ST_D_ACC;
        end
      end
      ST_I_ACC: begin
        i_waitrequest = 1'b0;
        state_d       = ST_IDLE;
        if (in_range) begin
          ram_address = widx;
          ram_read    = 1'b1;
          i_readdata  = ram_readdata;
        end
      end
      ST_D_ACC: begin
        // Out-of-range partial writes still take the RMW path so timing is uniform
        if (partial) begin
          state_d = ST_D_RMW_WR;
          if (in_range) begin
            ram_address = widx;
            ram_read    = 1'b1;
          end
        end else begin
          d_waitrequest = 1'b0;
          state_d       = ST_IDLE;
          if (in_range && wr_q && be_q == BE_FULL) begin
            ram_address   = widx;
            ram_write     = 1'b1;
            ram_writedata = wdata_q;
          end else if (in_range && !wr_q) begin
            ram_address = widx;
            ram_read    = 1'b1;
            d_readdata  = ram_readdata;
          end
        end
      end
      ST_D_RMW_WR: begin
        d_waitrequest = 1'b0;
        state_d       = ST_IDLE;
        if (in_range) begin
          ram_address   = widx;
          ram_write     = 1'b1;
          ram_writedata = merge_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 32x2048 RAM attached.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_address;
  logic        i_read;
  logic [31:0] i_readdata;
  logic        i_waitrequest;
  logic [31:0] d_address;
  logic        d_read;
  logic        d_write;
  logic [3:0]  d_byteenable;
  logic [31:0] d_writedata;
  logic [31:0] d_readdata;
  logic        d_waitrequest;
  logic [31:0] ram_address;
  logic        ram_read;
  logic        ram_write;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:2047];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_wr_data = 32'h0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.RAM_WORDS(2048), .ADDR_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_address     (i_address),
    .i_read        (i_read),
    .i_readdata    (i_readdata),
    .i_waitrequest (i_waitrequest),
    .d_address     (d_address),
    .d_read        (d_read),
    .d_write       (d_write),
    .d_byteenable  (d_byteenable),
    .d_writedata   (d_writedata),
    .d_readdata    (d_readdata),
    .d_waitrequest (d_waitrequest),
    .ram_address   (ram_address),
    .ram_read      (ram_read),
    .ram_write     (ram_write),
    .ram_writedata (ram_writedata),
    .ram_readdata  (ram_readdata)
  );

  // RAM returns junk unless strobed, so unstrobed reads cannot look correct
  assign ram_readdata = (ram_read && ram_address < 32'd2048) ? mem[ram_address[10:0]] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (ram_write) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= ram_address;
      last_wr_data <= ram_writedata;
      if (ram_address < 32'd2048) mem[ram_address[10:0]] <= ram_writedata;
    end
    if (ram_read) rd_cnt <= rd_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    i_address = 0; i_read = 0;
    d_address = 0; d_read = 0; d_write = 0; d_byteenable = 0; d_writedata = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Starts and ends one time unit after a rising edge.
  task automatic d_xfer(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be,
                        output int cyc, output logic [31:0] rdata);
    logic done;
    d_read = rd; d_write = wr; d_address = addr; d_writedata = data; d_byteenable = be;
    cyc = 0; rdata = 32'h0; done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      cyc++;
      if (!d_waitrequest) begin
        rdata = d_readdata;
        done  = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!done) check("d_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    d_read = 0; d_write = 0;
  endtask

  task automatic i_xfer(input logic [31:0] addr, output int cyc, output logic [31:0] rdata);
    logic done;
    i_read = 1; i_address = addr;
    cyc = 0; rdata = 32'h0; done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      cyc++;
      if (!i_waitrequest) begin
        rdata = i_readdata;
        done  = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!done) check("i_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    i_read = 0;
  endtask

  int          cyc;
  logic [31:0] rdata;
  int          w0, r0;
  logic [1:0]  rr_exp [8];

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #12;
    check("rst_ram_read", {31'b0, ram_read}, 32'd0);
    check("rst_ram_write", {31'b0, ram_write}, 32'd0);
    check("rst_ram_address", ram_address, 32'd0);
    check("rst_ram_writedata", ram_writedata, 32'd0);
    check("rst_i_readdata", i_readdata, 32'd0);
    check("rst_d_readdata", d_readdata, 32'd0);
    check("rst_waits", {30'b0, i_waitrequest, d_waitrequest}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Preload word 4 through the data port
    d_xfer(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, cyc, rdata);
    check("preload_cyc", cyc, 32'd2);

    // Instruction read, cycle by cycle
    i_read = 1; i_address = 32'h10;
    @(negedge clk);
    check("i_wait_c1", {31'b0, i_waitrequest}, 32'd1);
    check("i_ramrd_c1", {31'b0, ram_read}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("i_wait_c2", {31'b0, i_waitrequest}, 32'd0);
    check("i_rdata_c2", i_readdata, 32'hDEADBEEF);
    check("i_ramaddr_c2", ram_address, 32'd4);
    check("i_ramrd_c2", {31'b0, ram_read}, 32'd1);
    @(posedge clk); #1 i_read = 0;
    @(negedge clk);
    check("i_rdata_idle", i_readdata, 32'd0);
    @(posedge clk); #1;

    i_xfer(32'h12, cyc, rdata);
    check("i_unaligned_data", rdata, 32'hDEADBEEF);
    check("i_unaligned_cyc", cyc, 32'd2);

    // Full-word write then read back
    w0 = wr_cnt;
    d_xfer(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, cyc, rdata);
    check("fw_cyc", cyc, 32'd2);
    check("fw_wrcnt", wr_cnt - w0, 32'd1);
    check("fw_addr", last_wr_addr, 32'd8);
    check("fw_data", last_wr_data, 32'h11223344);
    d_xfer(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, cyc, rdata);
    check("fw_readback", rdata, 32'h11223344);
    check("dr_cyc", cyc, 32'd2);

    // Partial write: read-modify-write
    d_xfer(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'hF, cyc, rdata);
    w0 = wr_cnt; r0 = rd_cnt;
    d_xfer(1'b0, 1'b1, 32'h20, 32'h000000EE, 4'b0001, cyc, rdata);
    check("pw_cyc", cyc, 32'd3);
    check("pw_rdcnt", rd_cnt - r0, 32'd1);
    check("pw_wrcnt", wr_cnt - w0, 32'd1);
    check("pw_data", last_wr_data, 32'hAABBCCEE);
    check("pw_addr", last_wr_addr, 32'd8);

    // Empty byteenable: no strobes, two cycles
    w0 = wr_cnt; r0 = rd_cnt;
    d_xfer(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, cyc, rdata);
    check("be0_cyc", cyc, 32'd2);
    check("be0_strobes", (wr_cnt - w0) + (rd_cnt - r0), 32'd0);
    d_xfer(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, cyc, rdata);
    check("be0_readback", rdata, 32'hAABBCCEE);

    // Out of range accesses
    w0 = wr_cnt; r0 = rd_cnt;
    d_xfer(1'b0, 1'b1, 32'h2000, 32'h12345678, 4'hF, cyc, rdata);
    check("oor_w_cyc", cyc, 32'd2);
    check("oor_w_wrcnt", wr_cnt - w0, 32'd0);
    d_xfer(1'b1, 1'b0, 32'h2000, 32'h0, 4'h0, cyc, rdata);
    check("oor_r_data", rdata, 32'd0);
    check("oor_r_cyc", cyc, 32'd2);
    check("oor_r_rdcnt", rd_cnt - r0, 32'd0);
    d_xfer(1'b0, 1'b1, 32'h2004, 32'h12345678, 4'b0011, cyc, rdata);
    check("oor_pw_cyc", cyc, 32'd3);
    check("oor_pw_wrcnt", wr_cnt - w0, 32'd0);

    // Read and write together act as a write
    w0 = wr_cnt;
    d_xfer(1'b1, 1'b1, 32'h24, 32'h55667788, 4'hF, cyc, rdata);
    check("rw_wrcnt", wr_cnt - w0, 32'd1);
    d_xfer(1'b1, 1'b0, 32'h24, 32'h0, 4'h0, cyc, rdata);
    check("rw_readback", rdata, 32'h55667788);

    // Round-robin with both masters holding requests from reset
    do_reset();
    rr_exp = '{2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10};
    i_read = 1; i_address = 32'h10;
    d_read = 1; d_address = 32'h20;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("rr_wait_%0d", c), {30'b0, i_waitrequest, d_waitrequest}, {30'b0, rr_exp[c]});
      if (c == 1) check("rr_i_data", i_readdata, 32'hDEADBEEF);
      if (c == 3) check("rr_d_data", d_readdata, 32'hAABBCCEE);
      @(posedge clk); #1;
    end
    idle_inputs();
    @(posedge clk); #1;

    // Reset during the read phase of a partial write
    w0 = wr_cnt;
    d_write = 1; d_address = 32'h20; d_writedata = 32'h00005500; d_byteenable = 4'b0010;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_dacc_rd", {31'b0, ram_read}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_ram_read", {31'b0, ram_read}, 32'd0);
    check("abort_ram_write", {31'b0, ram_write}, 32'd0);
    check("abort_ram_address", ram_address, 32'd0);
    check("abort_d_readdata", d_readdata, 32'd0);
    idle_inputs();
    #1;
    check("abort_d_wait", {31'b0, d_waitrequest}, 32'd0);
    @(posedge clk); #1;
    check("abort_wrcnt", wr_cnt - w0, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    d_xfer(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, cyc, rdata);
    check("abort_after_data", rdata, 32'hAABBCCEE);
    check("abort_after_cyc", cyc, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
